rect_fill_engine: RTL and testbench

Hardware rectangle-fill engine for the DDR2 frame buffer. It accepts one rectangle command (corners, 24-bit color, frame base) and writes every covered pixel as masked 8-pixel DDR2 write bursts. It sits upstream of the request controller on the same af/wdf write-port protocol as the frame filler, and is driven by the graphics command processor.

---
 rtl/rect_fill_engine.sv | 157 +++++++++++++++
 tb/tb_rect_fill_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills an inclusive rectangle in the DDR2 frame buffer by
// issuing masked 8-pixel write bursts (one af push plus two wdf words each).
// Optional feature: define RECT_FILL_CLIP_EN to clip the rectangle to the
// visible SCREEN_W x SCREEN_H area; otherwise the raw 10-bit coordinates are used.
module rect_fill_engine #(
  parameter int unsigned SCREEN_W = 800,
  parameter int unsigned SCREEN_H = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [9:0]   x0,
  input  logic [9:0]   y0,
  input  logic [9:0]   x1,
  input  logic [9:0]   y1,
  input  logic [23:0]  color,
  input  logic [31:0]  frame_base,
  output logic         ready,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);

  typedef enum logic [1:0] {StIdle, StSetup, StWrite1, StWrite2} state_e;

  state_e      state_q;
  logic [9:0]  x0_q, y0_q, x1_q, y1_q;
  logic [23:0] color_q;
  logic [10:0] base_q;
  logic [6:0]  bx_q;
  logic [9:0]  row_q;

  logic [9:0]  x1_clip, y1_clip;
  logic        empty;
  logic        last_burst;
  logic [6:0]  nxt_bx;
  logic [9:0]  nxt_row;

  // Only bits [30:20] of the frame base reach the burst address.
  logic unused_base;
  assign unused_base = ^{frame_base[31], frame_base[19:0]};

  // Byte mask for one 4-pixel word of burst bx: 4'h0 for pixels inside [lo_x, hi_x].
  function automatic logic [15:0] word_mask(input logic [6:0] bx, input logic hi,
                                            input logic [9:0] lo_x, input logic [9:0] hi_x);
    logic [9:0] px;
    word_mask = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      px = {bx, hi, 2'(k)};
      if (px >= lo_x && px <= hi_x) word_mask[4*k +: 4] = 4'h0;
    end
  endfunction

  assign ready      = (state_q == StIdle);
  assign af_cmd_din = 3'b000;

  // Enables follow state and the live backpressure flags.
  always_comb begin
    af_wr_en  = (state_q == StWrite1) && !af_full && !wdf_full;
    wdf_wr_en = af_wr_en || ((state_q == StWrite2) && !wdf_full);
  end

  // Clipped far corner and empty-rectangle detection used in SETUP.
  always_comb begin
    x1_clip = x1_q;
    y1_clip = y1_q;
`ifdef RECT_FILL_CLIP_EN
    if (x1_q > 10'(SCREEN_W - 1)) x1_clip = 10'(SCREEN_W - 1);
    if (y1_q > 10'(SCREEN_H - 1)) y1_clip = 10'(SCREEN_H - 1);
`endif
    // A start corner beyond the clip limit always lands past the clipped far corner.
    empty = (x0_q > x1_clip) || (y0_q > y1_clip);
  end

  // Next burst position: bx runs across the row, then wraps and steps the row.
  always_comb begin
    last_burst = (bx_q == x1_q[9:3]) && (row_q == y1_q);
    nxt_bx     = bx_q + 7'd1;
    nxt_row    = row_q;
    if (bx_q == x1_q[9:3]) begin
      nxt_bx  = x0_q[9:3];
      nxt_row = row_q + 10'd1;
    end
  end

  // Command FSM with registered address, data and mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
      base_q       <= '0;
      bx_q         <= '0;
      row_q        <= '0;
      af_addr_din  <= '0;
      wdf_din      <= '0;
      wdf_mask_din <= 16'hFFFF;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            color_q <= color;
            base_q  <= frame_base[30:20];
            state_q <= StSetup;
          end
        end
        StSetup: begin
          x1_q <= x1_clip;
          y1_q <= y1_clip;
          if (empty) begin
            state_q <= StIdle;
          end else begin
            bx_q         <= x0_q[9:3];
            row_q        <= y0_q;
            af_addr_din  <= {base_q, y0_q, x0_q[9:3], 3'b000};
            wdf_din      <= {4{8'h00, color_q}};
            wdf_mask_din <= word_mask(x0_q[9:3], 1'b0, x0_q, x1_clip);
            state_q      <= StWrite1;
          end
        end
        StWrite1: begin
          if (af_wr_en) begin
            wdf_mask_din <= word_mask(bx_q, 1'b1, x0_q, x1_q);
            state_q      <= StWrite2;
          end
        end
        StWrite2: begin
          if (wdf_wr_en) begin
            if (last_burst) begin
              state_q <= StIdle;
            end else begin
              bx_q         <= nxt_bx;
              row_q        <= nxt_row;
              af_addr_din  <= {base_q, nxt_row, nxt_bx, 3'b000};
              wdf_mask_din <= word_mask(nxt_bx, 1'b0, x0_q, x1_q);
              state_q      <= StWrite1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: a pixel-level model fills expectation queues per
// command; one negedge process checks every push against them.
module tb_rect_fill_engine;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [9:0]   x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [23:0]  color = '0;
  logic [31:0]  frame_base = '0;
  logic         ready;
  logic         af_full = 1'b0, wdf_full = 1'b0;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;

  rect_fill_engine #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
    .clk(clk), .rst(rst), .valid(valid), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color(color), .frame_base(frame_base), .ready(ready),
    .af_full(af_full), .wdf_full(wdf_full), .af_cmd_din(af_cmd_din),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  m;
    logic         w0;
  } wexp_t;

  logic [30:0] exp_addr[$];
  wexp_t       exp_w[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Pixel-level reference: every burst of every covered row, in raster order.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1,
                             input logic [23:0] col, input logic [31:0] base);
    int    ex1;
    int    ey1;
    int    p;
    wexp_t w;
    ex1 = ax1;
    ey1 = ay1;
`ifdef RECT_FILL_CLIP_EN
    if (ex1 > SCREEN_W - 1) ex1 = SCREEN_W - 1;
    if (ey1 > SCREEN_H - 1) ey1 = SCREEN_H - 1;
    if (ax0 >= SCREEN_W || ay0 >= SCREEN_H) return;
`endif
    if (ax0 > ex1 || ay0 > ey1) return;
    for (int r = ay0; r <= ey1; r++) begin
      for (int b = ax0 / 8; b <= ex1 / 8; b++) begin
        exp_addr.push_back(31'(((base >> 20) & 32'h7FF) * 32'h10_0000 + r * 1024 + b * 8));
        for (int h = 0; h < 2; h++) begin
          w.d  = '0;
          w.m  = '0;
          w.w0 = (h == 0);
          for (int k = 0; k < 4; k++) begin
            p = b * 8 + h * 4 + k;
            w.d[32*k +: 32] = {8'h00, col};
            if (p < ax0 || p > ex1) w.m[4*k +: 4] = 4'hF;
          end
          exp_w.push_back(w);
        end
      end
    end
  endtask

  // Per-cycle compare of every push against the model queues.
  always @(negedge clk) begin
    wexp_t we;
    if (!rst) begin
      chk("af_cmd_din", af_cmd_din, 3'b000);
      chk("af push while full", af_wr_en && (af_full || wdf_full), 1'b0);
      chk("wdf push while full", wdf_wr_en && wdf_full, 1'b0);
      if (wdf_wr_en) begin
        if (exp_w.size() == 0) begin
          chk("unexpected wdf push", 1'b1, 1'b0);
        end else begin
          we = exp_w.pop_front();
          chk("wdf data", wdf_din, we.d);
          chk("wdf mask", wdf_mask_din, we.m);
          chk("af push with word0", af_wr_en, we.w0);
          if (af_wr_en) begin
            if (exp_addr.size() == 0) chk("unexpected af push", 1'b1, 1'b0);
            else chk("af addr", af_addr_din, exp_addr.pop_front());
          end
        end
      end else if (af_wr_en) begin
        chk("af push without wdf", 1'b1, 1'b0);
      end
    end
  end

  task automatic check_reset_state(input string name);
    chk({name, " ready"}, ready, 1'b1);
    chk({name, " af_wr_en"}, af_wr_en, 1'b0);
    chk({name, " wdf_wr_en"}, wdf_wr_en, 1'b0);
    chk({name, " af_addr"}, af_addr_din, 31'h0);
    chk({name, " wdf_din"}, wdf_din, 128'h0);
    chk({name, " wdf_mask"}, wdf_mask_din, 16'hFFFF);
  endtask

  // Issue one command (called #1 after a posedge with the DUT idle) and follow it
  // to completion. Stall windows, busy poke and reset are given in cycles after
  // acceptance (lat 1 = cycle after the accepting edge); negative disables.
  task automatic run_cmd(input string name, input logic [9:0] ax0, input logic [9:0] ay0,
                         input logic [9:0] ax1, input logic [9:0] ay1,
                         input logic [23:0] col, input logic [31:0] base,
                         input int af_from, input int af_len, input int wf_from,
                         input int wf_len, input int poke_at, input int rst_at,
                         input int exp_lat);
    int lat;
    build_model(ax0, ay0, ax1, ay1, col, base);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col; frame_base = base;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    chk({name, " ready low at T+1"}, ready, 1'b0);
    forever begin
      if (ready) break;
      if (lat > 3000) begin
        chk({name, " completion timeout"}, 1'b1, 1'b0);
        break;
      end
      af_full  = (lat >= af_from) && (lat < af_from + af_len);
      wdf_full = (lat >= wf_from) && (lat < wf_from + wf_len);
      rst      = (lat == rst_at);
      if (lat == poke_at) begin
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd15; y1 = 10'd1; valid = 1'b1;
      end
      @(posedge clk); #1;
      valid = 1'b0;
      lat++;
      if (rst) begin
        rst = 1'b0;
        af_full = 1'b0;
        wdf_full = 1'b0;
        exp_addr.delete();
        exp_w.delete();
        check_reset_state({name, " after reset"});
        return;
      end
    end
    af_full = 1'b0;
    wdf_full = 1'b0;
    if (exp_lat >= 0) chk({name, " ready latency"}, 128'(lat), 128'(exp_lat));
    chk({name, " af bursts left"}, 128'(exp_addr.size()), 128'd0);
    chk({name, " wdf words left"}, 128'(exp_w.size()), 128'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model against hand-computed values.
    build_model(3, 5, 3, 5, 24'hABCDEF, 32'h0010_0000);
    chk("model pixel bursts", 128'(exp_addr.size()), 128'd1);
    chk("model pixel addr", exp_addr[0], 31'h0010_1400);
    chk("model pixel mask0", exp_w[0].m, 16'h0FFF);
    chk("model pixel data hi", exp_w[0].d[127:96], 32'h00ABCDEF);
    chk("model pixel mask1", exp_w[1].m, 16'hFFFF);
    exp_addr.delete(); exp_w.delete();
    build_model(5, 2, 10, 3, 24'h123456, 32'h0);
    chk("model edge bursts", 128'(exp_addr.size()), 128'd4);
    chk("model edge b0 m0", exp_w[0].m, 16'hFFFF);
    chk("model edge b0 m1", exp_w[1].m, 16'h000F);
    chk("model edge b1 m0", exp_w[2].m, 16'hF000);
    chk("model edge b1 m1", exp_w[3].m, 16'hFFFF);
    chk("model edge row3 addr", exp_addr[2], 31'h0000_0C00);
    exp_addr.delete(); exp_w.delete();
    build_model(0, 0, 799, 0, 24'h00FF00, 32'h0);
    chk("model row bursts", 128'(exp_addr.size()), 128'd100);
    chk("model row last addr", exp_addr[99], 31'h318);
    exp_addr.delete(); exp_w.delete();

    run_cmd("pixel", 10'd3, 10'd5, 10'd3, 10'd5, 24'hABCDEF, 32'h0010_0000,
            -1, 0, -1, 0, -1, -1, 4);
    run_cmd("row", 10'd0, 10'd0, 10'd799, 10'd0, 24'h00FF00, 32'h0,
            -1, 0, -1, 0, 50, -1, 202);
    run_cmd("edge", 10'd5, 10'd2, 10'd10, 10'd3, 24'h123456, 32'h8123_4567,
            -1, 0, -1, 0, -1, -1, 10);
    run_cmd("stall", 10'd5, 10'd2, 10'd10, 10'd3, 24'h654321, 32'h0040_0000,
            2, 10, 13, 5, -1, -1, 25);
    run_cmd("empty x", 10'd20, 10'd0, 10'd10, 10'd0, 24'h111111, 32'h0,
            -1, 0, -1, 0, 1, -1, 2);
    run_cmd("empty y", 10'd0, 10'd9, 10'd7, 10'd8, 24'h222222, 32'h0,
            -1, 0, -1, 0, -1, -1, 2);
    run_cmd("abort", 10'd790, 10'd598, 10'd1000, 10'd700, 24'h333333, 32'h0020_0000,
            -1, 0, -1, 0, -1, 4, -1);
    run_cmd("pixel after reset", 10'd3, 10'd5, 10'd3, 10'd5, 24'hABCDEF, 32'h0010_0000,
            -1, 0, -1, 0, -1, -1, 4);
`ifdef RECT_FILL_CLIP_EN
    run_cmd("clip", 10'd790, 10'd598, 10'd1000, 10'd700, 24'h444444, 32'h0,
            -1, 0, -1, 0, -1, -1, 10);
    run_cmd("clip offscreen", 10'd800, 10'd0, 10'd900, 10'd3, 24'h555555, 32'h0,
            -1, 0, -1, 0, -1, -1, 2);
`else
    run_cmd("raw offscreen", 10'd1000, 10'd1000, 10'd1010, 10'd1001, 24'h444444, 32'h0,
            -1, 0, -1, 0, -1, -1, 10);
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("idle ready", ready, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
